entropy_conditioner: RTL and testbench
======================================

Name: entropy_conditioner

Overview:
Conditions a raw, asynchronous entropy source (e.g. a sampled ring oscillator pin) into debiased single random bits. It feeds the LFSR's `random` input.
- Pipeline: synchroniser, then clock-divided sampling, then von Neumann debiasing, plus a repetition-count health test.
- `random_bit` is 0 whenever no bit is available, so XORing it into the LFSR feedback is neutral on idle cycles.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw_in (>=2).
SAMPLE_DIV, 4, clocks between sample strobes (>=1; 1 = strobe every clock).
DIV_WIDTH, 8, width of the sample divider counter (must hold SAMPLE_DIV-1).
REP_LIMIT, 32, consecutive identical samples that trip the health test (>=2).
REP_WIDTH, 6, width of the repetition counter (must hold REP_LIMIT).
COUNT_WIDTH, 16, width of the emitted-bit counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
raw_in  input  1  asynchronous raw entropy source.
enable  input  1  sampling enable.
random_bit  output  1  debiased bit; 0 when random_valid=0.
random_valid  output  1  one-cycle pulse per emitted bit.
health_fail  output  1  sticky repetition-test failure flag.
bit_count  output  COUNT_WIDTH  saturating count of emitted bits.

Behaviour:
- Reset (rst=1 at a rising edge) clears the following to 0:
  - synchroniser flops, divider, repetition counter, last_sample, FSM (IDLE), stored first bit;
  - all outputs: random_bit, random_valid, health_fail, bit_count.
- rst overrides every other input in the same cycle, including mid-pair and while health_fail is set.
- Synchroniser: raw_in passes through SYNC_STAGES flops. The last stage is s. s runs regardless of enable.
- Divider:
  - Counts 0..SAMPLE_DIV-1 while enable=1. strobe=1 when enable=1 and div==SAMPLE_DIV-1; div then wraps to 0.
  - With enable=0, div is held at 0 and there is no strobe.
  - First strobe after enable rises comes SAMPLE_DIV cycles later.
- Repetition test, on each strobe:
  - First strobe after reset: rep_cnt=1.
  - s==last_sample: rep_cnt increments, saturating at REP_LIMIT.
  - Otherwise: rep_cnt=1.
  - last_sample<=s.
  - When the updated rep_cnt equals REP_LIMIT, health_fail<=1 in that same edge. It is sticky until rst.
  - rep_cnt and last_sample hold across enable=0.
- Debias FSM, states IDLE and HAVE_FIRST:
  - IDLE + strobe: first<=s, go to HAVE_FIRST.
  - HAVE_FIRST + strobe, s!=first: random_bit<=first, random_valid<=1, go to IDLE.
  - HAVE_FIRST + strobe, s==first: discard, go to IDLE.
  - enable=0 in HAVE_FIRST: return to IDLE and discard first.
- Health interlock:
  - While health_fail=1, or on the strobe that sets it, the FSM is forced to IDLE.
  - No random_valid pulse is emitted, even if the tripping strobe would complete a differing pair.
- Outputs:
  - Registered. random_valid is high for exactly one cycle after the completing strobe edge.
  - random_bit equals the emitted value only in that cycle; otherwise 0.
  - Minimum spacing between valid pulses: 2*SAMPLE_DIV cycles.
- bit_count increments on each valid pulse and saturates at all-ones (no wrap).
- Latency: a change on raw_in is visible in s after SYNC_STAGES edges. A bit is emitted one edge after the second strobe of its pair.

Test Plan:
- Defaults, raw_in held 0 then 1 across two consecutive strobes -> one random_valid pulse with random_bit=0, one cycle after the 2nd strobe; bit_count=1.
- raw_in 1 then 0 across a strobe pair -> random_bit=1 pulse. Pairs 1,1 and 0,0 -> no pulse, bit_count unchanged, FSM back in IDLE.
- REP_LIMIT=8, raw_in held 1 for 8 strobes -> health_fail rises on the 8th strobe edge and no valid pulse ever follows. Toggling raw_in afterwards -> still no pulses. rst -> health_fail=0 and normal operation resumes.
- enable dropped after the first strobe of a pair, re-raised later -> the first bit is discarded and the next pair starts fresh. The first strobe after re-enable comes SAMPLE_DIV cycles after enable rises.
- COUNT_WIDTH=4, alternating raw_in giving 20 valid pairs -> bit_count stops at 15 (no wrap).
- rst asserted in the HAVE_FIRST state with random_valid pending -> no pulse; all outputs 0 on the next cycle. SAMPLE_DIV=1 -> a strobe every clock and valid pulses no closer than 2 cycles apart.

Source files
------------

// File: rtl/entropy_conditioner.sv
// entropy_conditioner
//
// Turns a raw, asynchronous entropy source into debiased single random bits
// suitable for XORing into an LFSR feedback path.
//
// Pipeline: raw_in -> synchroniser -> divided sample strobe -> von Neumann
// debiaser, with a repetition-count health test watching every sample.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   raw_in       asynchronous raw entropy source
//   enable       sampling enable; dropping it abandons a half-built pair
//   random_bit   debiased bit, forced to 0 whenever random_valid is 0
//   random_valid one-cycle pulse per emitted bit
//   health_fail  sticky repetition-test failure, cleared only by rst
//   bit_count    saturating count of emitted bits
module entropy_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SAMPLE_DIV  = 4,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned REP_LIMIT   = 32,
  parameter int unsigned REP_WIDTH   = 6,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   raw_in,
  input  logic                   enable,
  output logic                   random_bit,
  output logic                   random_valid,
  output logic                   health_fail,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  typedef enum logic [0:0] {StIdle, StHaveFirst} state_e;

  localparam logic [DIV_WIDTH-1:0] DivLast = DIV_WIDTH'(SAMPLE_DIV - 1);
  localparam logic [REP_WIDTH-1:0] RepMax  = REP_WIDTH'(REP_LIMIT);

  // ---------------------------------------------------------------------------
  // Synchroniser; runs regardless of enable so s is always fresh.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sample divider. Held at 0 while disabled so the first strobe after
  // enable rises always lands SAMPLE_DIV cycles later.
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 strobe;

  assign strobe = enable && (div_q == DivLast);

  always_comb begin
    div_d = div_q;
    if (!enable || (div_q == DivLast)) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Repetition-count health test. With last_sample and rep_cnt both reset
  // to 0, the first strobe naturally yields rep_cnt=1 whatever s is.
  // ---------------------------------------------------------------------------
  logic [REP_WIDTH-1:0] rep_q, rep_next;
  logic                 last_q;
  logic                 trip;
  logic                 health_q, health_d;

  always_comb begin
    rep_next = REP_WIDTH'(1);
    if (s == last_q) begin
      rep_next = (rep_q == RepMax) ? RepMax : rep_q + REP_WIDTH'(1);
    end
  end

  assign trip     = strobe && (rep_next == RepMax);
  assign health_d = health_q | trip;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q    <= '0;
      last_q   <= 1'b0;
      health_q <= 1'b0;
    end else begin
      health_q <= health_d;
      if (strobe) begin
        rep_q  <= rep_next;
        last_q <= s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Von Neumann debias FSM. Emits the first bit of a differing pair; equal
  // pairs are discarded. The health interlock wins over everything, so the
  // strobe that trips the test can never complete a pair.
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   first_q, first_d;
  logic   valid_d, bit_d;

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    valid_d = 1'b0;
    bit_d   = 1'b0;
    if (health_q || trip) begin
      state_d = StIdle;
    end else if (!enable) begin
      state_d = StIdle;
    end else if (strobe) begin
      unique case (state_q)
        StIdle: begin
          first_d = s;
          state_d = StHaveFirst;
        end
        StHaveFirst: begin
          if (s != first_q) begin
            valid_d = 1'b1;
            bit_d   = first_q;
          end
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. bit_count moves on the same edge the pulse appears.
  // ---------------------------------------------------------------------------
  logic                   valid_q, bit_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (valid_d && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      bit_q   <= bit_d;
      count_q <= count_d;
    end
  end

  assign random_valid = valid_q;
  assign random_bit   = bit_q;
  assign health_fail  = health_q;
  assign bit_count    = count_q;

endmodule

// File: tb/tb_entropy_conditioner.sv
// Self-checking bench for entropy_conditioner. Three configurations share one
// stimulus stream; a behavioural model per configuration predicts every output
// each cycle, and directed sequences pin the model to hand-computed values.
module tb_entropy_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_in = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] dv, db, df;
  logic [15:0] c0;
  logic [3:0]  c1, c2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // u0: defaults; u1: strobe every clock, short health limit, 4-bit counter;
  // u2: 3-stage sync, divide by 3, short limit, 4-bit counter.
  entropy_conditioner u0 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .random_bit(db[0]), .random_valid(dv[0]), .health_fail(df[0]), .bit_count(c0)
  );

  entropy_conditioner #(
    .SYNC_STAGES(2), .SAMPLE_DIV(1), .DIV_WIDTH(2), .REP_LIMIT(8), .REP_WIDTH(4),
    .COUNT_WIDTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .random_bit(db[1]), .random_valid(dv[1]), .health_fail(df[1]), .bit_count(c1)
  );

  entropy_conditioner #(
    .SYNC_STAGES(3), .SAMPLE_DIV(3), .DIV_WIDTH(2), .REP_LIMIT(8), .REP_WIDTH(4),
    .COUNT_WIDTH(4)
  ) u2 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .enable(enable),
    .random_bit(db[2]), .random_valid(dv[2]), .health_fail(df[2]), .bit_count(c2)
  );

  function automatic int p_sd(int i);
    case (i) 0: return 4; 1: return 1; default: return 3; endcase
  endfunction
  function automatic int p_sync(int i);
    case (i) 0: return 2; 1: return 2; default: return 3; endcase
  endfunction
  function automatic int p_lim(int i);
    case (i) 0: return 32; default: return 8; endcase
  endfunction
  function automatic int p_cmax(int i);
    case (i) 0: return 65535; default: return 15; endcase
  endfunction
  function automatic int get_cnt(int i);
    case (i) 0: return int'(c0); 1: return int'(c1); default: return int'(c2); endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. s at edge n is the raw_in value seen SYNC edges earlier,
  // or 0 if that edge is not after the most recent reset. Strobes fall on every
  // SAMPLE_DIV-th edge of an unbroken enabled run.
  // ---------------------------------------------------------------------------
  bit raw_log [0:32767];
  int edge_n = 0;
  int rst_edge = -1;
  bit live = 1'b0;
  int run [3];
  int last_s [3];
  int streak [3];
  int pend_n [3];
  int pend_v [3];
  int e_valid [3];
  int e_bit [3];
  int e_fail [3];
  int e_cnt [3];

  always @(posedge clk) begin
    if (edge_n < 32768) raw_log[edge_n] = raw_in;
    for (int i = 0; i < 3; i++) begin
      int  k;
      int  s;
      bit  strobe;
      bit  tripped;
      k = edge_n - p_sync(i);
      s = (k >= 0 && k > rst_edge) ? int'(raw_log[k]) : 0;
      if (rst) begin
        run[i] = 0; last_s[i] = 0; streak[i] = 0; pend_n[i] = 0; pend_v[i] = 0;
        e_valid[i] = 0; e_bit[i] = 0; e_fail[i] = 0; e_cnt[i] = 0;
      end else begin
        e_valid[i] = 0;
        e_bit[i]   = 0;
        strobe  = enable && ((run[i] + 1) % p_sd(i) == 0);
        run[i]  = enable ? run[i] + 1 : 0;
        tripped = 1'b0;
        if (strobe) begin
          if (s == last_s[i]) streak[i] = (streak[i] + 1 > p_lim(i)) ? p_lim(i) : streak[i] + 1;
          else streak[i] = 1;
          last_s[i] = s;
          tripped = (streak[i] == p_lim(i));
        end
        if (!enable || e_fail[i] != 0 || tripped) begin
          pend_n[i] = 0;
        end else if (strobe) begin
          if (pend_n[i] == 0) begin
            pend_n[i] = 1;
            pend_v[i] = s;
          end else begin
            pend_n[i] = 0;
            if (pend_v[i] != s) begin
              e_valid[i] = 1;
              e_bit[i]   = pend_v[i];
              if (e_cnt[i] < p_cmax(i)) e_cnt[i]++;
            end
          end
        end
        if (tripped) e_fail[i] = 1;
      end
    end
    if (rst) begin
      rst_edge = edge_n;
      live = 1'b1;
    end
    edge_n++;
  end

  // Compare every cycle on the falling edge, once the model has seen a reset.
  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d valid", i), int'(dv[i]), e_valid[i]);
        check($sformatf("u%0d bit", i), int'(db[i]), e_bit[i]);
        check($sformatf("u%0d health", i), int'(df[i]), e_fail[i]);
        check($sformatf("u%0d count", i), get_cnt(i), e_cnt[i]);
      end
    end
  end

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; raw_in = 1'b0;
    tick(3);
    check("reset u0 valid", int'(dv[0]), 0);
    check("reset u0 count", int'(c0), 0);
    check("reset health", int'(df), 0);
    rst = 1'b0;
    tick(1);

    // Pair 0,1 -> bit 0 one cycle after the second strobe.
    enable = 1'b1;
    tick(4);
    check("u0 first of pair no pulse", int'(dv[0]), 0);
    raw_in = 1'b1;
    tick(4);
    check("u0 pair01 valid", int'(dv[0]), 1);
    check("u0 pair01 bit", int'(db[0]), 0);
    check("u0 pair01 count", int'(c0), 1);

    // Pair 1,0 -> bit 1.
    tick(4);
    check("u0 pulse one cycle", int'(dv[0]), 0);
    raw_in = 1'b0;
    tick(4);
    check("u0 pair10 valid", int'(dv[0]), 1);
    check("u0 pair10 bit", int'(db[0]), 1);
    check("u0 pair10 count", int'(c0), 2);

    // Pairs 0,0 and 1,1 are discarded.
    tick(8);
    check("u0 pair00 count", int'(c0), 2);
    raw_in = 1'b1;
    tick(8);
    check("u0 pair11 valid", int'(dv[0]), 0);
    check("u0 pair11 count", int'(c0), 2);

    // enable drop after a first sample discards it.
    raw_in = 1'b0;
    tick(4);
    enable = 1'b0;
    raw_in = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(4);
    check("u0 reenable first strobe no pulse", int'(dv[0]), 0);
    raw_in = 1'b0;
    tick(4);
    check("u0 fresh pair valid", int'(dv[0]), 1);
    check("u0 fresh pair bit", int'(db[0]), 1);
    check("u0 fresh pair count", int'(c0), 3);

    // Reset on the edge that would complete a differing pair.
    tick(4);
    raw_in = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst mid-pair valid", int'(dv[0]), 0);
    check("rst mid-pair count", int'(c0), 0);
    check("rst mid-pair bit", int'(db[0]), 0);

    // u1 health test: raw held 1, trips on the 10th strobe after reset
    // (two leading zeros from the cleared synchroniser, then eight ones).
    tick(1);
    rst = 1'b0;
    tick(9);
    check("u1 health before limit", int'(df[1]), 0);
    tick(1);
    check("u1 health at limit", int'(df[1]), 1);
    for (int j = 0; j < 20; j++) begin
      raw_in = ~raw_in;
      tick(1);
    end
    check("u1 no pulses after fail", int'(c1), 0);
    check("u1 health sticky", int'(df[1]), 1);
    rst = 1'b1;
    tick(1);
    check("u1 health cleared", int'(df[1]), 0);
    rst = 1'b0;

    // Alternating raw_in on u1 yields a pulse every two cycles; counter saturates.
    for (int j = 0; j < 60; j++) begin
      raw_in = ~raw_in;
      tick(1);
    end
    check("u1 count saturates", int'(c1), 15);
    check("model u1 count saturates", e_cnt[1], 15);

    // Randomized segments.
    for (int seg = 0; seg < 70; seg++) begin
      int mode;
      int len;
      int bias;
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        enable = 1'b1;
        raw_in = 1'($urandom_range(0, 1));
        tick(int'($urandom_range(130, 200)));
      end else if (mode == 1) begin
        rst = 1'b1;
        tick(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end else begin
        len  = int'($urandom_range(20, 120));
        bias = int'($urandom_range(20, 80));
        for (int j = 0; j < len; j++) begin
          raw_in = ($urandom_range(0, 99) < bias);
          enable = ($urandom_range(0, 99) < 92);
          tick(1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
